sprite_line_scheduler: RTL
==========================

// Module: sprite_line_scheduler
// PURPOSE
//  Per-scanline scheduler for the sprite colour/collision ROMs. During hblank it scans the
//  object table and picks up to NUM_SLOTS entries that overlap the next line. Each chosen
//  32-bit entry drives the table_val input of one sprite-ROM instance. The list is
//  double-buffered: the scan fills a shadow list, and line_commit copies it to the active list.
// PARAMETERS
//  NUM_OBJ    16  object table depth (power of 2); obj_rd_addr width = $clog2(NUM_OBJ)
//  NUM_SLOTS  4   sprite-ROM instances fed per line
// PORTS
//  Clk          in   1            system clock
//  Reset_n      in   1            asynchronous, active-low reset
//  line_start   in   1            1-cycle pulse at hblank start; begin scan for next_line
//  next_line    in   10           DrawY of the line to be scheduled; sampled on line_start
//  line_commit  in   1            1-cycle pulse just before DrawX==0 of that line
//  obj_rd_addr  out  log2(NUM_OBJ) object table read address
//  obj_rd_data  in   32           table entry; valid 1 cycle after obj_rd_addr (sync RAM)
//  slot_val     out  32*NUM_SLOTS active entries; slot k = [32k+31:32k]
//  slot_valid   out  NUM_SLOTS    active slot k holds a real entry
//  busy         out  1            scan in progress
//  scan_done    out  1            1-cycle pulse when shadow list is complete
//  overflow     out  1            more than NUM_SLOTS hits on the last scanned line (sticky/line)
//  late_commit  out  1            1-cycle pulse: commit arrived while busy
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. Shadow and active lists are 0 (type 0 = draws nothing).
//  Entry fields: type=[31:26], X=[23:14], Y=[13:4].
//  Height from type:
//    6'h04, 6'h05 -> 21
//    6'h06..6'h09 -> 33
//    any other type (incl. 0) -> never a hit
//  Hit: H!=0 && Y <= L && L < Y+H. L is the latched next_line. Compute Y+H in 11 bits (no wrap).
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//    IDLE: on line_start, latch L, clear shadow list, count=0, overflow=0, busy=1,
//      obj_rd_addr=0, go to SCAN.
//    SCAN: obj_rd_addr increments each cycle from 0 to NUM_OBJ-1 and then holds.
//      Data for address i is evaluated on the cycle after i is issued.
//      On a hit with count<NUM_SLOTS: write the entry to shadow[count] and increment count.
//      On a hit with count==NUM_SLOTS: set overflow; the entry is dropped.
//      Lower table index always wins. After entry NUM_OBJ-1 is evaluated, go to DONE.
//      Scan length = NUM_OBJ+1 cycles from line_start.
//    DONE: scan_done=1 for one cycle, busy=0, go to IDLE.
//  line_commit when not busy: on the next edge, active list <= shadow list.
//    slot_valid[k] = (k < count). Unfilled slots hold 32'h0.
//  line_commit while busy: active list cleared (all slots 0, slot_valid=0),
//    late_commit pulses, scan continues.
//  line_start while busy: the scan restarts from index 0 with the new next_line and the
//    shadow list is cleared. No scan_done for the aborted scan.
//  line_start and line_commit in the same cycle: the commit copies the prior completed shadow
//    first, then the new scan begins (the scan-start clear does not affect the committed copy).
//  Active list is stable between commits. Outputs are registered, with no combinational
//    path from inputs.
//  Reset mid-scan: immediate return to IDLE with both lists cleared.
// TESTING
//  1. Reset: Reset_n=0 mid-scan -> busy=0, slot_valid=0, slot_val=0, obj_rd_addr=0.
//  2. Table[2]={6'h04,X=100,Y=50}, Table[7]={6'h07,X=200,Y=40}, L=60, commit
//     -> slot0=Table[2], slot1=Table[7], slot_valid=4'b0011, scan_done 17 cycles after line_start.
//  3. Edges for type 6'h04, Y=50: L=50 hit, L=70 hit, L=71 miss, L=49 miss.
//     Type 0 and type 6'h0A at Y=L -> never selected.
//  4. Six hits at indices 1,3,4,8,9,15 -> slots = indices 1,3,4,8; overflow=1.
//     Next scan with 2 hits -> overflow=0.
//  5. line_commit 5 cycles after line_start -> late_commit pulse, slot_valid=0.
//     The scan still completes with scan_done.
//  6. line_start at scan cycle 8 with new L -> restart at addr 0. Exactly one scan_done,
//     17 cycles after the second pulse. The shadow list reflects only the new L.
//     Also: simultaneous line_start+line_commit -> active list = previous shadow.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Purpose : per-scanline sprite scheduler; scans the object table during hblank, keeps the first NUM_SLOTS hits.
// Latency : scan_done NUM_OBJ+1 cycles after line_start; active list updates the edge after line_commit.
// Backpressure: none; a commit during a scan blanks the active list, a new line_start restarts the scan.
module sprite_line_scheduler #(
    parameter int NUM_OBJ   = 16,
    parameter int NUM_SLOTS = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       line_start,
    input  logic [9:0]                 next_line,
    input  logic                       line_commit,
    output logic [$clog2(NUM_OBJ)-1:0] obj_rd_addr,
    input  logic [31:0]                obj_rd_data,
    output logic [32*NUM_SLOTS-1:0]    slot_val,
    output logic [NUM_SLOTS-1:0]       slot_valid,
    output logic                       busy,
    output logic                       scan_done,
    output logic                       overflow,
    output logic                       late_commit
);

    localparam int AW = $clog2(NUM_OBJ);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int SW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                    state;
    logic [9:0]                cur_line;
    logic [SW-1:0]             cyc;
    logic [CW-1:0]             count;
    logic [32*NUM_SLOTS-1:0]   shadow;

    logic [5:0]                ent_type;
    logic [9:0]                ent_y;
    logic [5:0]                height;
    logic [10:0]               y_end;
    logic                      hit;

    assign ent_type = obj_rd_data[31:26];
    assign ent_y    = obj_rd_data[13:4];

    // Sprite height from the entry type; zero height means the entry never draws.
    always_comb begin
        height = 6'd0;
        case (ent_type)
            6'h04, 6'h05:               height = 6'd21;
            6'h06, 6'h07, 6'h08, 6'h09: height = 6'd33;
            default:                    height = 6'd0;
        endcase
    end

    // Bottom edge computed one bit wider so sprites near line 1023 do not wrap.
    assign y_end = {1'b0, ent_y} + {5'b0, height};
    assign hit   = (height != 6'd0) && (ent_y <= cur_line) && ({1'b0, cur_line} < y_end);

    // Scan FSM, shadow fill, and double-buffer commit; every output is a flop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            cur_line    <= '0;
            cyc         <= '0;
            count       <= '0;
            shadow      <= '0;
            obj_rd_addr <= '0;
            slot_val    <= '0;
            slot_valid  <= '0;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
            overflow    <= 1'b0;
            late_commit <= 1'b0;
        end else begin
            scan_done   <= 1'b0;
            late_commit <= 1'b0;

            // Commit reads the shadow before any same-cycle scan start clears it.
            if (line_commit) begin
                if (busy) begin
                    slot_val    <= '0;
                    slot_valid  <= '0;
                    late_commit <= 1'b1;
                end else begin
                    slot_val <= shadow;
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        slot_valid[k] <= (CW'(k) < count);
                    end
                end
            end

            if (line_start) begin
                state       <= S_SCAN;
                cur_line    <= next_line;
                cyc         <= '0;
                count       <= '0;
                shadow      <= '0;
                overflow    <= 1'b0;
                busy        <= 1'b1;
                obj_rd_addr <= '0;
            end else begin
                case (state)
                    S_SCAN: begin
                        if (obj_rd_addr != AW'(NUM_OBJ - 1)) begin
                            obj_rd_addr <= obj_rd_addr + 1'b1;
                        end
                        cyc <= cyc + 1'b1;
                        // Read data lags the address by one cycle, so nothing is valid at cyc==0.
                        if ((cyc != '0) && hit) begin
                            if (count == CW'(NUM_SLOTS)) begin
                                overflow <= 1'b1;
                            end else begin
                                for (int k = 0; k < NUM_SLOTS; k++) begin
                                    if (count == CW'(k)) begin
                                        shadow[k*32 +: 32] <= obj_rd_data;
                                    end
                                end
                                count <= count + 1'b1;
                            end
                        end
                        if (cyc == SW'(NUM_OBJ)) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            scan_done <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
